// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and defaults
package alu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} serial_state_t;
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic i_1,
  input  logic i_2,
  input  logic i_3,
  output logic s,
  output logic c
);
  assign s = i_1 ^ i_2 ^ i_3;
  assign c = (i_1 & i_2) | (i_3 & (i_1 ^ i_2));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder over one full_adder; SERIAL_ADD_SUB_EN adds i_sub (A-B)
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  serial_state_t    r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [WIDTH-2:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_cout, r_ovf;
  logic             w_s, w_c, w_accept, w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_in   = i_sub ? ~i_b : i_b;
  assign w_cin_in = i_sub | i_cin;
`else
  assign w_b_in   = i_b;
  assign w_cin_in = i_cin;
`endif
  full_adder u_fa (
    .i_1(r_a[0]),
    .i_2(r_b[0]),
    .i_3(r_carry),
    .s  (w_s),
    .c  (w_c)
  );
  assign w_accept = (r_state == ST_IDLE) && i_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  always_ff @(posedge clk)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    o_ready = r_state == ST_IDLE;
    o_valid = r_state == ST_DONE;
    case (r_state)
      ST_IDLE: w_next = i_valid ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = i_ready ? ST_IDLE : ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end
  // r_res collects the low WIDTH-1 sum bits; the MSB joins them at the final edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= (WIDTH-1)'({w_s, r_res} >> 1);
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {w_s, r_res};
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int W = 32;
  logic clk, rst, i_valid, o_ready, i_cin, o_valid, i_ready, o_cout, o_ovf;
  logic [W-1:0] i_a, i_b, o_sum;
`ifdef SERIAL_ADD_SUB_EN
  logic i_sub;
`endif
  int total = 0;
  int bad = 0;
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub(i_sub),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
  );
  always #5 clk = ~clk;
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    i_valid = 1'b1; i_a = a; i_b = b; i_cin = cin;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) begin
        i_a = $urandom; i_b = $urandom; i_cin = 1'($urandom_range(0, 1));
      end
    end
  endtask
  task automatic drain();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask
  task automatic test_reset();
    int lat;
    bit seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_sum !== '0) begin bad++; $display("FAIL reset_sum got=%h exp=0", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {o_cout, o_ovf}); end
    start_op(32'd5, 32'd3, 1'b0);
    wait_done(1'b0, lat);
    drain();
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL midrun_handshake got=%b%b exp=10", o_ready, o_valid); end
    total++; if (o_sum !== '0) begin bad++; $display("FAIL midrun_sum got=%h exp=0", o_sum); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrun_ghost got=1 exp=0"); end
  endtask
  task automatic test_basic();
    int lat;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", o_ready); end
    start_op(32'd5, 32'd3, 1'b0);
    wait_done(1'b0, lat);
    total++; if (lat != W) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    total++; if (o_sum !== 32'd8) begin bad++; $display("FAIL basic_sum got=%h exp=8", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {o_cout, o_ovf}); end
    drain();
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL basic_release got=%b%b exp=10", o_ready, o_valid); end
  endtask
  task automatic test_carry();
    logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] vb [3] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    logic         vc [3] = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [1:0]   ef [3] = '{2'b10, 2'b01, 2'b11};
    int lat;
    for (int k = 0; k < 3; k++) begin
      start_op(va[k], vb[k], vc[k]);
      wait_done(1'b0, lat);
      total++; if (o_sum !== es[k]) begin bad++; $display("FAIL carry_sum[%0d] got=%h exp=%h", k, o_sum, es[k]); end
      total++; if ({o_cout, o_ovf} !== ef[k]) begin bad++; $display("FAIL carry_flags[%0d] got=%b exp=%b", k, {o_cout, o_ovf}, ef[k]); end
      drain();
    end
  endtask
  task automatic test_backpressure();
    int lat;
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done(1'b0, lat);
    i_valid = 1'b1; i_a = 32'h10; i_b = 32'h20; i_cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin bad++; $display("FAIL stall_hs[%0d] got=%b%b exp=10", k, o_valid, o_ready); end
      total++; if (o_sum !== 32'h100) begin bad++; $display("FAIL stall_sum[%0d] got=%h exp=100", k, o_sum); end
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b%b exp=10", o_ready, o_valid); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_accept got=%b exp=0", o_ready); end
    wait_done(1'b0, lat);
    total++; if (lat != W) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", lat, W); end
    total++; if (o_sum !== 32'h30) begin bad++; $display("FAIL stall_next_sum got=%h exp=30", o_sum); end
    drain();
  endtask
  task automatic test_isolation();
    int lat;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(1'b1, lat);
    total++; if (lat != W) begin bad++; $display("FAIL iso_latency got=%0d exp=%0d", lat, W); end
    total++; if (o_sum !== 32'h2345_6789 || o_cout !== 1'b0) begin bad++; $display("FAIL iso_sum got=%h/%b exp=23456789/0", o_sum, o_cout); end
    drain();
  endtask
  task automatic test_back_to_back();
    int lat;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(1'b0, lat);
    total++; if (o_sum !== 32'h2345_6789) begin bad++; $display("FAIL b2b_first got=%h exp=23456789", o_sum); end
    drain();
    start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    wait_done(1'b0, lat);
    total++; if (lat != W) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, W); end
    total++; if (o_sum !== 32'h1010_1011) begin bad++; $display("FAIL b2b_second got=%h exp=10101011", o_sum); end
    drain();
  endtask
`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat;
    i_sub = 1'b1;
    start_op(32'd5, 32'd7, 1'b0);
    i_sub = 1'b0;
    wait_done(1'b0, lat);
    total++; if (o_sum !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_sum0 got=%h exp=fffffffe", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL sub_flags0 got=%b exp=00", {o_cout, o_ovf}); end
    drain();
    i_sub = 1'b1;
    start_op(32'h8000_0000, 32'd1, 1'b0);
    i_sub = 1'b0;
    wait_done(1'b0, lat);
    total++; if (o_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_sum1 got=%h exp=7fffffff", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b11) begin bad++; $display("FAIL sub_flags1 got=%b exp=11", {o_cout, o_ovf}); end
    drain();
  endtask
`endif
  initial begin
    clk = 1'b0; rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    i_sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_isolation();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
